// File: rtl/dm_arbiter.sv
// Data-memory arbiter: round-robin CPU/debug sharing of a single-port memory,
// bounds checking, and a sequenced zero-fill sweep that locks out both requesters.

module dm_arb_port #(
  parameter int DEPTH = 3072,
  parameter int IDX_W = 12
) (
  input  logic [29:0]      waddr,
  output logic [IDX_W-1:0] idx,
  output logic             oob
);
  // A full word-address compare covers both the index range and stray high bits.
  assign idx = waddr[IDX_W-1:0];
  assign oob = (waddr >= 30'(DEPTH));
endmodule

module dm_arbiter #(
  parameter int DEPTH = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rd,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wd,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rd,
  output logic        dbg_rvalid,
  output logic        oob_err,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int NUM_REQ = 2;
  localparam int CPU     = 0;
  localparam int DBG     = 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  clr_state_t                     state;
  logic [IDX_W-1:0]               clr_idx;
  logic                           last;   // 1: debug was granted most recently
  req_t [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             oob;
  logic [NUM_REQ-1:0][IDX_W-1:0]  idx;
  logic                           arb_en;
  logic                           win;

  assign req[CPU] = '{we: cpu_we, addr: cpu_addr, wd: cpu_wd};
  assign req[DBG] = '{we: dbg_we, addr: dbg_addr, wd: dbg_wd};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    dm_arb_port #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_port (
      .waddr (req[g].addr[31:2]),
      .idx   (idx[g]),
      .oob   (oob[g])
    );
  end

  assign arb_en   = ~reset & (state == IDLE);
  assign gnt[CPU] = arb_en & cpu_req & (~dbg_req | last);
  assign gnt[DBG] = arb_en & dbg_req & (~cpu_req | ~last);
  assign win      = gnt[DBG];

  assign cpu_gnt   = gnt[CPU];
  assign dbg_gnt   = gnt[DBG];
  assign cpu_stall = cpu_req & ~gnt[CPU];
  assign cpu_rd    = oob[CPU] ? '0 : mem_rd;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (~reset && state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = {{(30-IDX_W){1'b0}}, clr_idx, 2'b00};
    end else if (|gnt) begin
      mem_we   = req[win].we & ~oob[win];
      mem_addr = {{(30-IDX_W){1'b0}}, idx[win], 2'b00};
      mem_wd   = req[win].wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clr_idx    <= '0;
      last       <= 1'b1;
      dbg_rd     <= '0;
      dbg_rvalid <= 1'b0;
      oob_err    <= 1'b0;
      clr_done   <= 1'b0;
      clr_busy   <= 1'b0;
    end else begin
      if (|gnt) last <= gnt[DBG];
      dbg_rvalid <= gnt[DBG] & ~dbg_we;
      if (gnt[DBG] & ~dbg_we) dbg_rd <= oob[DBG] ? '0 : mem_rd;
      oob_err  <= |(gnt & oob);
      clr_done <= 1'b0;
      case (state)
        IDLE: if (clr_start) begin
          state    <= CLEAR;
          clr_idx  <= '0;
          clr_busy <= 1'b1;
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state    <= DONE;
            clr_idx  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
